one_hot_channel_sequencer: RTL

- Time-multiplexes one shared LED bit-driver across NUM_CHANNELS strip outputs by rotating a registered one-hot grant.
- Generalises the fixed 5-bit one-hot rotator with:
  - parametrised channel count
  - per-channel enable mask, so disabled strips are skipped
  - up/down direction
  - done-handshake dwell per channel
  - single-frame and loop modes
  - frame/wrap status pulses and a binary index output
- Sits between the frame scheduler (start/abort/mode) and the output mux feeding the strip pins.

---
 rtl/ledsuit_seq_pkg.sv | 15 +
 rtl/onehot_next_select.sv | 47 ++++
 rtl/one_hot_channel_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/ledsuit_seq_pkg.sv
// Shared types and constants for the LED strip channel sequencer.
// Imported by the sequencer top and its next-channel search.
package ledsuit_seq_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } seq_state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int MAX_CHANNELS = 32;

endpackage

// File: rtl/onehot_next_select.sv
// Combinational priority search over the channel enable mask.
// Yields the first enabled channel and the next one after cur_idx_i.
module onehot_next_select
    import ledsuit_seq_pkg::*;
#(
    parameter int NUM_CHANNELS = 5,
    parameter int IDX_W        = 3
) (
    input  logic [IDX_W-1:0]        cur_idx_i,
    input  logic [NUM_CHANNELS-1:0] mask_i,
    input  logic                    dir_i,
    output logic [IDX_W-1:0]        next_idx_o,
    output logic                    has_next_o,
    output logic [IDX_W-1:0]        first_idx_o,
    output logic                    mask_empty_o
);

    always_comb begin
        next_idx_o   = '0;
        has_next_o   = 1'b0;
        first_idx_o  = '0;
        mask_empty_o = (mask_i == '0);
        // Scan away from the search direction so the last hit is the nearest.
        if (dir_i == DIR_UP) begin
            for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
                if (mask_i[i]) begin
                    first_idx_o = IDX_W'(i);
                end
                if (mask_i[i] && (i > int'(cur_idx_i))) begin
                    next_idx_o = IDX_W'(i);
                    has_next_o = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (mask_i[i]) begin
                    first_idx_o = IDX_W'(i);
                end
                if (mask_i[i] && (i < int'(cur_idx_i))) begin
                    next_idx_o = IDX_W'(i);
                    has_next_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/one_hot_channel_sequencer.sv
// Rotates a registered one-hot grant over enabled LED strip channels,
// advancing on the shared driver's done handshake.
module one_hot_channel_sequencer
    import ledsuit_seq_pkg::*;
#(
    parameter int NUM_CHANNELS = 5,
    parameter int IDX_W        = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CHANNELS-1:0] enable_mask,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    dir,
    input  logic                    loop,
    input  logic                    done,
    output logic [NUM_CHANNELS-1:0] grant,
    output logic [IDX_W-1:0]        grant_idx,
    output logic                    active,
    output logic                    wrap,
    output logic                    frame_done,
    output logic                    fault
);

    seq_state_t              state_q;
    logic [NUM_CHANNELS-1:0] grant_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    wrap_q;
    logic                    frame_done_q;
    logic                    fault_q;

    logic [IDX_W-1:0] next_idx;
    logic             has_next;
    logic [IDX_W-1:0] first_idx;
    logic             mask_empty;

    onehot_next_select #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .IDX_W        (IDX_W)
    ) u_sel (
        .cur_idx_i    (idx_q),
        .mask_i       (enable_mask),
        .dir_i        (dir),
        .next_idx_o   (next_idx),
        .has_next_o   (has_next),
        .first_idx_o  (first_idx),
        .mask_empty_o (mask_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            idx_q        <= '0;
            wrap_q       <= 1'b0;
            frame_done_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            wrap_q       <= 1'b0;
            frame_done_q <= 1'b0;
            fault_q      <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                grant_q <= '0;
                idx_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            if (mask_empty) begin
                                fault_q <= 1'b1;
                            end else begin
                                state_q <= ACTIVE;
                                idx_q   <= first_idx;
                                grant_q <= NUM_CHANNELS'(1) << first_idx;
                            end
                        end
                    end
                    ACTIVE: begin
                        if (done) begin
                            if (mask_empty) begin
                                state_q <= IDLE;
                                grant_q <= '0;
                                idx_q   <= '0;
                                fault_q <= 1'b1;
                            end else if (has_next) begin
                                idx_q   <= next_idx;
                                grant_q <= NUM_CHANNELS'(1) << next_idx;
                            end else if (loop) begin
                                idx_q        <= first_idx;
                                grant_q      <= NUM_CHANNELS'(1) << first_idx;
                                wrap_q       <= 1'b1;
                                frame_done_q <= 1'b1;
                            end else begin
                                state_q      <= IDLE;
                                grant_q      <= '0;
                                idx_q        <= '0;
                                frame_done_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        idx_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign grant      = grant_q;
    assign grant_idx  = idx_q;
    assign active     = (state_q == ACTIVE);
    assign wrap       = wrap_q;
    assign frame_done = frame_done_q;
    assign fault      = fault_q;

endmodule
